sha256d_nonce_scheduler: RTL and testbench
==========================================

Name: sha256d_nonce_scheduler

Overview:
- Sequences the pipelined SHA-256 block core for Bitcoin-style double hashing over a nonce range.
- Per nonce it issues two core passes:
  - pass 1: header tail block, with the job midstate as IV;
  - pass 2: pass-1 digest padded, with the standard SHA-256 IV.
- Compares each final hash against a 256-bit target and reports hits.
- Sits between the job/host interface and one core instance, and is the core's only requester.

Parameters:
STOP_ON_FOUND, 1, 1 = end the job after the first hit; 0 = continue to the end of the range.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  scheduler accepts job (IDLE and no core result outstanding)
job_midstate  in  256  IV for pass 1 (big-endian words)
job_tail  in  96  header bytes 64..75 as block words 0..2
job_nonce_start  in  32  first nonce
job_nonce_end  in  32  last nonce (inclusive)
job_target  in  256  hit threshold
abort  in  1  cancel current job
core_start  out  1  core request
core_ready  in  1  core can accept
core_iv  out  256  core IV
core_block  out  512  core block
core_digest  in  256  core result
core_digest_valid  in  1  core result strobe
found_valid  out  1  one-cycle hit pulse
found_nonce  out  32  nonce of hit
found_hash  out  256  pass-2 digest of hit, as output by core
done  out  1  one-cycle job-end pulse
done_found  out  1  qualifies done: at least one hit this job
hashes_done  out  32  nonces completed in current/last job
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - all outputs 0 except job_ready = 1;
  - state IDLE;
  - outstanding = 0;
  - all job registers 0.
- Job acceptance: on job_valid && job_ready:
  - latch all job_* fields;
  - nonce <= job_nonce_start;
  - hashes_done <= 0, done_found <= 0;
  - go to P1_ISSUE.
- States: IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, DRAIN.
- P1_ISSUE:
  - core_start = 1, core_iv = midstate;
  - core_block words 0..2 = tail;
  - word 3 = byteswap(nonce);
  - word 4 = 0x80000000;
  - words 5..14 = 0;
  - word 15 = 0x00000280.
  - On core_start && core_ready: set outstanding, go to P1_WAIT.
  - core_iv/core_block are held stable while core_start = 1.
- P1_WAIT: on core_digest_valid, capture d1, clear outstanding, go to P2_ISSUE.
- P2_ISSUE:
  - core_iv = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19;
  - core_block = d1 || 0x80000000 || six zero words || 0x00000100;
  - same handshake as P1_ISSUE, then go to P2_WAIT.
- P2_WAIT, on core_digest_valid:
  - hash value v = byte-reverse of the 256-bit core_digest;
  - hit = (v <= target), unsigned 256-bit compare;
  - hashes_done++.
  - If hit: found_valid = 1 next cycle, with found_nonce = nonce and found_hash = core_digest; set done_found.
  - If (hit && STOP_ON_FOUND) or nonce == nonce_end: done pulse next cycle, go to IDLE.
  - Otherwise: nonce <= nonce + 1 (mod 2^32), go to P1_ISSUE.
- Range:
  - count = ((end - start) mod 2^32) + 1;
  - start > end wraps through 0xFFFFFFFF;
  - start == end hashes one nonce;
  - start == end + 1 (mod 2^32) hashes all 2^32 nonces.
- Latency:
  - the controller is core-latency-insensitive;
  - with the 65-cycle core, one pass is 66 cycles from ISSUE to the next state;
  - nonce period is 132 cycles;
  - found_valid/done appear 132 cycles after a nonce's P1_ISSUE cycle.
- Abort, in any non-IDLE state:
  - next state is DRAIN if outstanding, else IDLE;
  - core_start drops immediately (combinational from state);
  - no found_valid or done for the aborted job;
  - a digest arriving in DRAIN is discarded, clears outstanding, and returns to IDLE;
  - abort in IDLE is ignored.
- job_ready = (state == IDLE); job_valid is ignored otherwise.
- Simultaneous events:
  - abort wins over core_digest_valid in WAIT states: the digest is discarded, outstanding clears, go to IDLE;
  - abort wins over a start handshake in ISSUE states: if core_start && core_ready && abort, the request counts as accepted, so go to DRAIN.
- Asynchronous reset mid-job returns to reset values. The core must be reset by the same rst_n.

Test Plan:
- Genesis block: midstate/tail from the bench model, range 2083236890..2083236895, target = genesis hash value 0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f -> exactly one found_valid with found_nonce = 2083236893 (0x7C2BAC1D), hashes_done = 4, done with done_found = 1, done 4*132 cycles after acceptance.
- Wrap range 0xFFFFFFFE..0x00000001, target 0 -> 4 nonces in order FFFFFFFE, FFFFFFFF, 00000000, 00000001; no found; done with done_found = 0; hashes_done = 4.
- STOP_ON_FOUND = 0, target all-ones, range 5..7 -> three found_valid pulses (nonces 5, 6, 7) 132 cycles apart, then done.
- Abort asserted 10 cycles into P1_WAIT -> core_start stays 0; job_ready stays 0 until the in-flight digest arrives; then IDLE with no found/done pulses; the next job runs normally.
- Core stub holding core_ready = 0 for 20 cycles in P1_ISSUE -> core_start held with stable iv/block; exactly one handshake; period extends by 20.
- Reset asserted during P2_WAIT -> all outputs return to reset values immediately; no found_valid after release.

Source files
------------

// File: rtl/sha256d_nonce_scheduler.sv
// sha256d_nonce_scheduler: walks a nonce range through a pipelined SHA-256
// block core, two passes per nonce, and reports digests at or below target.
module sha256d_nonce_scheduler #(
  parameter bit STOP_ON_FOUND = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_tail,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         core_start,
  input  logic         core_ready,
  output logic [255:0] core_iv,
  output logic [511:0] core_block,
  input  logic [255:0] core_digest,
  input  logic         core_digest_valid,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         done,
  output logic         done_found,
  output logic [31:0]  hashes_done,
  output logic         busy
);

  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {
    IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, DRAIN
  } state_t;

  state_t       state;
  logic         outstanding;
  logic [255:0] midstate;
  logic [255:0] target;
  logic [255:0] d1;
  logic [95:0]  tail;
  logic [31:0]  nonce;
  logic [31:0]  nonce_end;
  logic [255:0] value;
  logic         hit;
  logic         last;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Bitcoin compares the digest read as a little-endian number
  always_comb begin
    value = '0;
    for (int i = 0; i < 32; i++)
      value[8*i +: 8] = core_digest[255-8*i -: 8];
  end

  assign hit  = value <= target;
  assign last = (hit && STOP_ON_FOUND) || (nonce == nonce_end);

  assign job_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign core_start = (state == P1_ISSUE) || (state == P2_ISSUE);

  always_comb begin
    core_iv    = '0;
    core_block = '0;
    unique case (1'b1)
      state == P1_ISSUE: begin
        core_iv    = midstate;
        core_block = {tail, bswap32(nonce), 32'h80000000,
                      320'h0, 32'h00000280};
      end
      state == P2_ISSUE: begin
        core_iv    = SHA_IV;
        core_block = {d1, 32'h80000000, 192'h0, 32'h00000100};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outstanding <= 1'b0;
      midstate    <= '0;
      target      <= '0;
      d1          <= '0;
      tail        <= '0;
      nonce       <= '0;
      nonce_end   <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      done        <= 1'b0;
      done_found  <= 1'b0;
      hashes_done <= '0;
    end else begin
      found_valid <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            midstate    <= job_midstate;
            tail        <= job_tail;
            nonce       <= job_nonce_start;
            nonce_end   <= job_nonce_end;
            target      <= job_target;
            hashes_done <= '0;
            done_found  <= 1'b0;
            state       <= P1_ISSUE;
          end
        end
        P1_ISSUE, P2_ISSUE: begin
          if (core_ready)
            outstanding <= 1'b1;
          // an accepted request must still be drained on abort
          if (abort)
            state <= core_ready ? DRAIN : IDLE;
          else if (core_ready)
            state <= (state == P1_ISSUE) ? P1_WAIT : P2_WAIT;
        end
        P1_WAIT: begin
          if (core_digest_valid)
            outstanding <= 1'b0;
          if (abort) begin
            state <= core_digest_valid ? IDLE : DRAIN;
          end else if (core_digest_valid) begin
            d1    <= core_digest;
            state <= P2_ISSUE;
          end
        end
        P2_WAIT: begin
          if (core_digest_valid)
            outstanding <= 1'b0;
          if (abort) begin
            state <= core_digest_valid ? IDLE : DRAIN;
          end else if (core_digest_valid) begin
            hashes_done <= hashes_done + 32'd1;
            if (hit) begin
              found_valid <= 1'b1;
              found_nonce <= nonce;
              found_hash  <= core_digest;
              done_found  <= 1'b1;
            end
            if (last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              nonce <= nonce + 32'd1;
              state <= P1_ISSUE;
            end
          end
        end
        DRAIN: begin
          if (core_digest_valid) begin
            outstanding <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Bench for sha256d_nonce_scheduler: behavioural SHA-256 core model,
// directed scenarios plus randomized jobs checked against a double-hash model.
module tb_sha256d_nonce_scheduler;

  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [2047:0] K = {
    256'h428a2f9871374491b5c0fbcfe9b5dba53956c25b59f111f1923f82a4ab1c5ed5,
    256'hd807aa9812835b01243185be550c7dc372be5d7480deb1fe9bdc06a7c19bf174,
    256'he49b69c1efbe47860fc19dc6240ca1cc2de92c6f4a7484aa5cb0a9dc76f988da,
    256'h983e5152a831c66db00327c8bf597fc7c6e00bf3d5a7914706ca635114292967,
    256'h27b70a852e1b21384d2c6dfc53380d13650a7354766a0abb81c2c92e92722c85,
    256'ha2bfe8a1a81a664bc24b8b70c76c51a3d192e819d6990624f40e3585106aa070,
    256'h19a4c1161e376c082748774c34b0bcb5391c0cb34ed8aa4a5b9cca4f682e6ff3,
    256'h748f82ee78a5636f84c878148cc7020890befffaa4506cebbef9a3f7c67178f2};
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] GEN_V =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  typedef struct { int inst; int due; logic [255:0] d; } pend_t;
  typedef struct { int inst; logic [31:0] n; logic [255:0] h; int c; } fev_t;
  typedef struct { int inst; int c; logic df; logic [31:0] hd; } dev_t;
  typedef struct { int inst; logic [31:0] w; } p1_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt [2];

  logic [1:0]   jv, jr, ab, cr, cs, dv, fv, dn, dfd, bsy;
  logic [255:0] j_mid, j_tgt;
  logic [95:0]  j_tail;
  logic [31:0]  j_s, j_e;
  logic [255:0] civ [2];
  logic [511:0] cblk [2];
  logic [255:0] dig [2];
  logic [31:0]  fnon [2];
  logic [255:0] fhash [2];
  logic [31:0]  hd [2];

  pend_t pq [$];
  fev_t  fq [$];
  dev_t  dq [$];
  p1_t   p1q [$];
  logic [31:0]  exp_n [$];
  logic [255:0] exp_h [$];
  int exp_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256d_nonce_scheduler #(.STOP_ON_FOUND(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .job_valid(jv[0]), .job_ready(jr[0]),
    .job_midstate(j_mid), .job_tail(j_tail), .job_nonce_start(j_s),
    .job_nonce_end(j_e), .job_target(j_tgt), .abort(ab[0]),
    .core_start(cs[0]), .core_ready(cr[0]), .core_iv(civ[0]),
    .core_block(cblk[0]), .core_digest(dig[0]), .core_digest_valid(dv[0]),
    .found_valid(fv[0]), .found_nonce(fnon[0]), .found_hash(fhash[0]),
    .done(dn[0]), .done_found(dfd[0]), .hashes_done(hd[0]), .busy(bsy[0]));

  sha256d_nonce_scheduler #(.STOP_ON_FOUND(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .job_valid(jv[1]), .job_ready(jr[1]),
    .job_midstate(j_mid), .job_tail(j_tail), .job_nonce_start(j_s),
    .job_nonce_end(j_e), .job_target(j_tgt), .abort(ab[1]),
    .core_start(cs[1]), .core_ready(cr[1]), .core_iv(civ[1]),
    .core_block(cblk[1]), .core_digest(dig[1]), .core_digest_valid(dv[1]),
    .found_valid(fv[1]), .found_nonce(fnon[1]), .found_hash(fhash[1]),
    .done(dn[1]), .done_found(dfd[1]), .hashes_done(hd[1]), .busy(bsy[1]));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] iv,
                                                input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = iv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[2047-32*i -: 32] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++)
      r[255-32*i -: 32] = iv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] pad(input logic [511:0] data,
                                       input int nb, input int total);
    logic [511:0] b;
    b = data;
    b[511-8*nb -: 8] = 8'h80;
    b[63:0] = 64'(total * 8);
    return b;
  endfunction

  function automatic logic [31:0] le32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] dhash(input logic [255:0] mid,
                                         input logic [95:0] tl,
                                         input logic [31:0] n);
    logic [255:0] h1;
    h1 = sha_compress(mid, pad({tl, le32(n), 384'h0}, 16, 80));
    return sha_compress(SHA_IV, pad({h1, 256'h0}, 32, 32));
  endfunction

  function automatic pend_t mk_pend(int g, int due, logic [255:0] d);
    pend_t p;
    p.inst = g; p.due = due; p.d = d;
    return p;
  endfunction

  function automatic fev_t mk_fev(int g, logic [31:0] n, logic [255:0] h,
                                  int c);
    fev_t f;
    f.inst = g; f.n = n; f.h = h; f.c = c;
    return f;
  endfunction

  function automatic dev_t mk_dev(int g, int c, logic df, logic [31:0] h);
    dev_t d;
    d.inst = g; d.c = c; d.df = df; d.hd = h;
    return d;
  endfunction

  function automatic p1_t mk_p1(int g, logic [31:0] w);
    p1_t p;
    p.inst = g; p.w = w;
    return p;
  endfunction

  // pipelined core model: result strobe 64 edges after the accepting edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      dv <= 2'b00;
    end else begin
      dv <= 2'b00;
      while (pq.size() > 0 && pq[0].due == cyc) begin
        dv[pq[0].inst] <= 1'b1;
        dig[pq[0].inst] <= pq[0].d;
        void'(pq.pop_front());
      end
      for (int g = 0; g < 2; g++) begin
        if (cs[g] && cr[g]) begin
          pq.push_back(mk_pend(g, cyc + 64, sha_compress(civ[g], cblk[g])));
          hs_cnt[g] <= hs_cnt[g] + 1;
          if (cblk[g][31:0] == 32'h280)
            p1q.push_back(mk_p1(g, cblk[g][415:384]));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (fv[g]) fq.push_back(mk_fev(g, fnon[g], fhash[g], cyc));
      if (dn[g]) dq.push_back(mk_dev(g, cyc, dfd[g], hd[g]));
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_job(input int g, input logic [255:0] mid,
                           input logic [95:0] tl, input logic [31:0] s,
                           input logic [31:0] e, input logic [255:0] tgt);
    logic [31:0] n;
    logic [255:0] h;
    bit hit;
    n = s;
    exp_n.delete();
    exp_h.delete();
    exp_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      h = dhash(mid, tl, n);
      hit = bswap256(h) <= tgt;
      exp_cnt++;
      if (hit) begin
        exp_n.push_back(n);
        exp_h.push_back(h);
      end
      if ((hit && g == 0) || n == e) break;
      n = n + 32'd1;
    end
  endtask

  task automatic start_job(input int g, input logic [255:0] mid,
                           input logic [95:0] tl, input logic [31:0] s,
                           input logic [31:0] e, input logic [255:0] tgt,
                           output int acc);
    fq.delete();
    dq.delete();
    p1q.delete();
    chk("job_ready_idle", jr[g], 1);
    j_mid = mid; j_tail = tl; j_s = s; j_e = e; j_tgt = tgt;
    jv[g] = 1'b1;
    @(negedge clk);
    jv[g] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int g, input int budget, input bit rnd);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (dn[g] === 1'b1) break;
      if (rnd) cr[g] = ($urandom_range(0, 3) != 0);
    end
    cr[g] = 1'b1;
    chk("done_in_budget", n < budget, 1);
    #1;
  endtask

  initial begin
    int a, bad, hs0, g, len;
    logic [255:0] mid, tgt;
    logic [95:0] tl;
    logic [31:0] s;
    logic [511:0] eblk;

    rst_n = 1'b0;
    jv = 2'b00; ab = 2'b00; cr = 2'b11;
    j_mid = '0; j_tail = '0; j_s = '0; j_e = '0; j_tgt = '0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_job_ready", jr[i], 1);
      chk("rst_busy", bsy[i], 0);
      chk("rst_core_start", cs[i], 0);
      chk("rst_core_iv", civ[i], 0);
      chk("rst_core_block", cblk[i][255:0], 0);
      chk("rst_found", {fv[i], dn[i], dfd[i]}, 0);
      chk("rst_found_hash", fhash[i], 0);
      chk("rst_counts", {fnon[i], hd[i]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // genesis block
    mid = sha_compress(SHA_IV, {32'h01000000, 256'h0,
      224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa});
    tl = 96'h4b1e5e4a29ab5f49ffff001d;
    start_job(0, mid, tl, 32'd2083236890, 32'd2083236895, GEN_V, a);
    wait_done(0, 700, 1'b0);
    chk("gen_found_count", fq.size(), 1);
    if (fq.size() > 0) begin
      chk("gen_found_nonce", fq[0].n, 32'h7C2BAC1D);
      chk("gen_found_hash", bswap256(fq[0].h), GEN_V);
      chk("gen_found_cycle", fq[0].c, a + 528);
    end
    chk("gen_done_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("gen_done_found", dq[0].df, 1);
      chk("gen_hashes_done", dq[0].hd, 4);
      chk("gen_done_cycle", dq[0].c, a + 528);
    end
    chk("gen_idle_after", jr[0], 1);

    // range wrapping through 0xFFFFFFFF
    mid = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
    start_job(0, mid, tl, 32'hFFFFFFFE, 32'h00000001, 256'h0, a);
    wait_done(0, 700, 1'b0);
    chk("wrap_found_count", fq.size(), 0);
    chk("wrap_p1_count", p1q.size(), 4);
    for (int k = 0; k < 4 && k < p1q.size(); k++)
      chk("wrap_nonce_order", p1q[k].w, le32(32'hFFFFFFFE + k));
    chk("wrap_done_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("wrap_done_found", dq[0].df, 0);
      chk("wrap_hashes_done", dq[0].hd, 4);
      chk("wrap_done_cycle", dq[0].c, a + 528);
    end

    // continue past hits
    start_job(1, mid, tl, 32'd5, 32'd7, ONES, a);
    wait_done(1, 600, 1'b0);
    chk("cont_found_count", fq.size(), 3);
    for (int k = 0; k < 3 && k < fq.size(); k++) begin
      chk("cont_found_nonce", fq[k].n, 5 + k);
      chk("cont_found_cycle", fq[k].c, a + 132 * (k + 1));
    end
    if (fq.size() > 0)
      chk("cont_found_hash", fq[0].h, dhash(mid, tl, 32'd5));
    chk("cont_done_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("cont_done_found", dq[0].df, 1);
      chk("cont_hashes_done", dq[0].hd, 3);
      chk("cont_done_cycle", dq[0].c, a + 396);
    end

    // abort ten cycles into the first wait
    start_job(0, mid, tl, 32'd100, 32'd200, 256'h0, a);
    repeat (10) @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    bad = 0;
    while (cyc < a + 66) begin
      if (cs[0] !== 1'b0 || jr[0] !== 1'b0 || bsy[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("abort_drain_hold", bad, 0);
    chk("abort_idle_after_digest", jr[0], 1);
    repeat (140) @(negedge clk);
    chk("abort_no_found", fq.size(), 0);
    chk("abort_no_done", dq.size(), 0);

    // core stalls the first request for 20 cycles
    s = $urandom;
    eblk = pad({tl, le32(s), 384'h0}, 16, 80);
    cr[0] = 1'b0;
    hs0 = hs_cnt[0];
    start_job(0, mid, tl, s, s, ONES, a);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (cs[0] !== 1'b1 || civ[0] !== mid || cblk[0] !== eblk) bad++;
      @(negedge clk);
    end
    chk("stall_request_stable", bad, 0);
    chk("stall_no_handshake", hs_cnt[0] - hs0, 0);
    cr[0] = 1'b1;
    wait_done(0, 300, 1'b0);
    chk("stall_handshakes", hs_cnt[0] - hs0, 2);
    chk("stall_done_count", dq.size(), 1);
    if (dq.size() > 0) chk("stall_done_cycle", dq[0].c, a + 152);

    // reset during the second nonce's pass-2 wait
    start_job(1, mid, tl, 32'd0, 32'd3, ONES, a);
    while (cyc < a + 210) @(negedge clk);
    chk("rst_mid_pre_hashes", hd[1], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_job_ready", jr[1], 1);
    chk("rst_mid_busy", {bsy[1], cs[1]}, 0);
    chk("rst_mid_counts", {hd[1], fnon[1]}, 0);
    chk("rst_mid_flags", {fv[1], dn[1], dfd[1]}, 0);
    chk("rst_mid_found_hash", fhash[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    fq.delete();
    dq.delete();
    repeat (300) @(negedge clk);
    chk("rst_mid_no_found", fq.size(), 0);
    chk("rst_mid_no_done", dq.size(), 0);

    // randomized jobs with random core back-pressure
    for (int i = 0; i < 6; i++) begin
      g = i % 2;
      len = $urandom_range(1, 4);
      s = $urandom;
      tgt = {8'($urandom_range(0, 255)), {248{1'b1}}};
      mid = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      tl = {$urandom, $urandom, $urandom};
      model_job(g, mid, tl, s, s + len - 1, tgt);
      start_job(g, mid, tl, s, s + len - 1, tgt, a);
      wait_done(g, 3000, 1'b1);
      chk("rnd_done_count", dq.size(), 1);
      if (dq.size() > 0) begin
        chk("rnd_done_found", dq[0].df, exp_n.size() > 0);
        chk("rnd_hashes_done", dq[0].hd, exp_cnt);
      end
      chk("rnd_found_count", fq.size(), exp_n.size());
      for (int k = 0; k < fq.size() && k < exp_n.size(); k++) begin
        chk("rnd_found_nonce", fq[k].n, exp_n[k]);
        chk("rnd_found_hash", fq[k].h, exp_h[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
